game_clock_ctrl: RTL
====================

// Module: game_clock_ctrl
// PURPOSE
//   Sequences the scoreboard game clock: owns the 1 s prescaler, counts each
//   quarter down from QUARTER_MIN:00, handles start/stop, quarter advance,
//   end-of-quarter horn and game-over. Feeds minutes/seconds/quarter to the
//   display drivers. Button inputs arrive as debounced 1-cycle pulses.
// PARAMETERS
//   TICKS_PER_SEC  50000000  clk cycles per game second (>=2)
//   QUARTER_MIN    15        quarter length in minutes (1..99)
//   NUM_QTRS       4         quarters per game (1..7)
//   HORN_SEC       3         horn duration in seconds at quarter end (>=1)
// PORTS
//   clk         in   1   system clock
//   rst         in   1   synchronous, active-high reset
//   start_stop  in   1   1-cycle pulse: start/pause/resume
//   next_qtr    in   1   1-cycle pulse: advance after quarter end
//   minutes     out  7   remaining minutes (0..QUARTER_MIN)
//   seconds     out  6   remaining seconds (0..59)
//   quarter     out  3   current quarter (1..NUM_QTRS)
//   running     out  1   high only in RUNNING
//   horn        out  1   horn drive
//   sec_tick    out  1   1-cycle pulse at each prescaler terminal count
//   state       out  3   IDLE=0 RUNNING=1 PAUSED=2 QTR_END=3 GAME_OVER=4
// BEHAVIOUR
//   Reset (sync, rst high at clk edge): state=IDLE, minutes=QUARTER_MIN,
//     seconds=0, quarter=1, running=0, horn=0, sec_tick=0, prescaler=0.
//     rst overrides every other input in every state.
//   Prescaler: 32-bit, counts 0..TICKS_PER_SEC-1 only in RUNNING and QTR_END;
//     at TICKS_PER_SEC-1 it wraps to 0 and sec_tick=1 for that next cycle.
//     Held (not cleared) in PAUSED; cleared on entry to RUNNING from IDLE
//     and on entry to QTR_END.
//   IDLE: start_stop -> RUNNING. next_qtr ignored.
//   RUNNING: on each terminal count decrement time: seconds>0 -> seconds-1;
//     else minutes-1, seconds=59. If the new value is 0:00 -> QTR_END and
//     horn=1 in the same update. start_stop -> PAUSED. next_qtr ignored.
//   Simultaneous terminal count + start_stop in RUNNING: decrement applied
//     and state -> PAUSED, unless decrement reaches 0:00 (QTR_END wins,
//     start_stop dropped).
//   PAUSED: time frozen; start_stop -> RUNNING, prescaler resumes from held
//     value (fractional second preserved). next_qtr ignored.
//   QTR_END: time held at 0:00. horn stays high for HORN_SEC terminal counts,
//     then clears. start_stop ignored. next_qtr: if quarter<NUM_QTRS ->
//     quarter+1, minutes=QUARTER_MIN, seconds=0, horn=0, IDLE; else ->
//     GAME_OVER, horn=0, quarter unchanged. next_qtr accepted even while horn
//     still sounding.
//   GAME_OVER: all outputs frozen, horn=0; only rst exits.
//   All outputs registered; response appears the cycle after the input pulse.
//   Never decrement below 0:00; minutes never exceeds QUARTER_MIN.
// TESTING (TICKS_PER_SEC=4, QUARTER_MIN=1, NUM_QTRS=2, HORN_SEC=2)
//   Reset 2 cycles -> 1:00, quarter=1, state=0, horn=0, running=0.
//   start_stop, wait 4 cycles -> sec_tick once, time 0:59, running=1.
//   Run 2 cycles, start_stop, idle 20 cycles -> 0:59 frozen, state=2;
//     start_stop -> 0:58 exactly 2 cycles later (prescaler preserved).
//   Run to expiry (240 cycles from start) -> 0:00, state=3, horn high 8 cycles
//     then 0; start_stop during QTR_END -> no change.
//   next_qtr -> quarter=2, 1:00, state=0; run out; next_qtr -> state=4,
//     quarter=2; further start_stop/next_qtr -> no change.
//   Assert rst while RUNNING at 0:30 -> next cycle 1:00, quarter=1, IDLE;
//     also start_stop on terminal-count cycle at 0:59 -> 0:58 and state=2.

Source files
------------

// File: rtl/game_clock_ctrl.sv
// Scoreboard game clock sequencer: 1 s prescaler, quarter countdown,
// start/stop, quarter advance, end-of-quarter horn and game-over handling.
module game_clock_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned QUARTER_MIN   = 15,
  parameter int unsigned NUM_QTRS      = 4,
  parameter int unsigned HORN_SEC      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       next_qtr,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] quarter,
  output logic       running,
  output logic       horn,
  output logic       sec_tick,
  output logic [2:0] state
);

  localparam int unsigned PRESC_W = 32;
  localparam int unsigned HCNT_W  = 32;
  localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [HCNT_W-1:0]  HORN_LAST = HCNT_W'(HORN_SEC - 1);
  localparam logic [6:0]         QMIN      = 7'(QUARTER_MIN);
  localparam logic [2:0]         QLAST     = 3'(NUM_QTRS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUNNING   = 3'd1,
    S_PAUSED    = 3'd2,
    S_QTR_END   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [6:0]         min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic [2:0]         qtr_q, qtr_d;
  logic               running_q, running_d;
  logic               horn_q, horn_d;
  logic               tick_q, tick_d;

  logic               counting;
  logic               term;
  logic [6:0]         dec_min;
  logic [5:0]         dec_sec;
  logic               dec_zero;

  // Next-state, prescaler, countdown and horn logic
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hcnt_d    = hcnt_q;
    min_d     = min_q;
    sec_d     = sec_q;
    qtr_d     = qtr_q;
    horn_d    = horn_q;
    running_d = 1'b0;
    tick_d    = 1'b0;
    dec_min   = min_q;
    dec_sec   = sec_q;

    counting = (state_q == S_RUNNING) || (state_q == S_QTR_END);
    term     = counting && (presc_q == PRESC_TC);

    if (counting) begin
      presc_d = term ? '0 : presc_q + PRESC_W'(1);
    end
    tick_d = term;

    // One-second decrement, saturating at 0:00
    if (sec_q != 6'd0) begin
      dec_sec = sec_q - 6'd1;
    end else if (min_q != 7'd0) begin
      dec_min = min_q - 7'd1;
      dec_sec = 6'd59;
    end
    dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);

    case (state_q)
      S_IDLE: begin
        if (start_stop) begin
          state_d = S_RUNNING;
          presc_d = '0;
        end
      end
      S_RUNNING: begin
        if (term) begin
          min_d = dec_min;
          sec_d = dec_sec;
        end
        if (term && dec_zero) begin
          state_d = S_QTR_END;
          horn_d  = 1'b1;
          hcnt_d  = '0;
          presc_d = '0;
        end else if (start_stop) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (start_stop) begin
          state_d = S_RUNNING;
        end
      end
      S_QTR_END: begin
        if (term && horn_q) begin
          if (hcnt_q >= HORN_LAST) begin
            horn_d = 1'b0;
          end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end
        end
        if (next_qtr) begin
          horn_d = 1'b0;
          if (qtr_q < QLAST) begin
            qtr_d   = qtr_q + 3'd1;
            min_d   = QMIN;
            sec_d   = 6'd0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAME_OVER;
          end
        end
      end
      S_GAME_OVER: begin
        horn_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d = (state_d == S_RUNNING);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      hcnt_q    <= '0;
      min_q     <= QMIN;
      sec_q     <= 6'd0;
      qtr_q     <= 3'd1;
      running_q <= 1'b0;
      horn_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hcnt_q    <= hcnt_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      qtr_q     <= qtr_d;
      running_q <= running_d;
      horn_q    <= horn_d;
      tick_q    <= tick_d;
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign quarter  = qtr_q;
  assign running  = running_q;
  assign horn     = horn_q;
  assign sec_tick = tick_q;
  assign state    = state_q;

endmodule
